spatz_hybrid_sram_ctrl: RTL and testbench

//  Banked SRAM slice shared by the L1 cache controller (one port per bank) and NumSpmPorts scratchpad ports.

---
 rtl/spatz_hybrid_sram_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spatz_hybrid_sram_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_hybrid_sram_ctrl.sv
// Banked SRAM slice shared by the L1 cache (one port per bank) and SPM ports, with a runtime way partition.
// Define SPATZ_SRAM_PERF_EN to add saturating conflict and forced-starvation-grant counters.
module spatz_hybrid_sram_ctrl #(
   parameter int unsigned NumWay                = 4,
   parameter int unsigned BankFactor            = 2,
   parameter int unsigned NumWords              = 2048,
   parameter int unsigned DataWidth             = 64,
   parameter int unsigned ByteWidth             = 8,
   parameter int unsigned NumSpmPorts           = 2,
   parameter int unsigned MemoryResponseLatency = 1,
   parameter int unsigned StarveLimit           = 4,
   localparam int unsigned NumBanks      = NumWay * BankFactor,
   localparam int unsigned BankSelWidth  = $clog2(NumBanks),
   localparam int unsigned BankAddrWidth = $clog2(NumWords / NumBanks),
   localparam int unsigned MemAddrWidth  = $clog2(NumWords),
   localparam int unsigned BeWidth       = DataWidth / ByteWidth,
   localparam int unsigned CfgWidth      = $clog2(NumWay + 1)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumBanks-1:0]                 cache_req_i,
   input  logic [NumBanks-1:0]                 cache_we_i,
   input  logic [NumBanks*BankAddrWidth-1:0]   cache_addr_i,
   input  logic [NumBanks*DataWidth-1:0]       cache_wdata_i,
   input  logic [NumBanks*BeWidth-1:0]         cache_be_i,
   output logic [NumBanks-1:0]                 cache_gnt_o,
   output logic [NumBanks-1:0]                 cache_rvalid_o,
   output logic [NumBanks*DataWidth-1:0]       cache_rdata_o,
   input  logic [NumSpmPorts-1:0]              spm_req_i,
   input  logic [NumSpmPorts-1:0]              spm_we_i,
   input  logic [NumSpmPorts*MemAddrWidth-1:0] spm_addr_i,
   input  logic [NumSpmPorts*DataWidth-1:0]    spm_wdata_i,
   input  logic [NumSpmPorts*BeWidth-1:0]      spm_be_i,
   output logic [NumSpmPorts-1:0]              spm_gnt_o,
   output logic [NumSpmPorts-1:0]              spm_rvalid_o,
   output logic [NumSpmPorts*DataWidth-1:0]    spm_rdata_o,
   input  logic [CfgWidth-1:0]                 cfg_spm_ways_i,
   input  logic                                cfg_valid_i,
   output logic                                cfg_ready_o,
   output logic [CfgWidth-1:0]                 cfg_spm_ways_o
`ifdef SPATZ_SRAM_PERF_EN
   ,
   output logic [31:0]                         perf_conflict_o,
   output logic [31:0]                         perf_starve_o
`endif
);

   localparam int unsigned WordsPerBank = NumWords / NumBanks;
   localparam int unsigned SpmIdxW      = (NumSpmPorts > 1) ? $clog2(NumSpmPorts) : 1;
   localparam int unsigned StarveW      = $clog2(StarveLimit + 1);
   localparam int unsigned Lat          = MemoryResponseLatency;

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

   state_e                   r_state, w_state_nxt;
   logic [CfgWidth-1:0]      r_spm_ways, r_cfg_pend, w_cfg_clamped;
   logic                     w_accept, w_pipe_busy;
   logic [NumBanks-1:0]      w_owned, w_force, w_nondef_req, w_cache_win, w_spm_win;
   logic [NumSpmPorts-1:0]   w_spm_hit [NumBanks];
   logic [SpmIdxW-1:0]       w_spm_sel [NumBanks];
   logic [StarveW-1:0]       r_starve  [NumBanks];
   logic [SpmIdxW-1:0]       r_rr      [NumBanks];

   logic [NumBanks-1:0]      w_bank_go, w_bank_we, w_bank_src;
   logic [SpmIdxW-1:0]       w_bank_port  [NumBanks];
   logic [BankAddrWidth-1:0] w_bank_addr  [NumBanks];
   logic [DataWidth-1:0]     w_bank_wdata [NumBanks];
   logic [BeWidth-1:0]       w_bank_be    [NumBanks];

   logic [Lat-1:0]           r_pv [NumBanks];
   logic [Lat-1:0]           r_ps [NumBanks];
   logic [SpmIdxW-1:0]       r_pp [NumBanks][Lat];
   logic [DataWidth-1:0]     r_pd [NumBanks][Lat];
   logic [DataWidth-1:0]     r_mem [NumBanks][WordsPerBank];

   // Per-bank arbitration: default class wins unless the other class has starved StarveLimit cycles.
   always_comb begin
      logic        v_cache_has, v_spm_has, v_found;
      int unsigned v_idx;
      for (int b = 0; b < NumBanks; b++) begin
         w_spm_hit[b] = '0;
         for (int p = 0; p < NumSpmPorts; p++)
            w_spm_hit[b][p] = spm_req_i[p] &&
                              (spm_addr_i[p*MemAddrWidth +: BankSelWidth] == BankSelWidth'(b));
         w_owned[b]      = CfgWidth'(b / BankFactor) < r_spm_ways;
         v_cache_has     = cache_req_i[b];
         v_spm_has       = |w_spm_hit[b];
         w_nondef_req[b] = w_owned[b] ? v_cache_has : v_spm_has;
         w_force[b]      = w_nondef_req[b] && (r_starve[b] == StarveW'(StarveLimit));
         w_cache_win[b]  = v_cache_has && (w_owned[b] ? (!v_spm_has || w_force[b]) : !w_force[b]);
         w_spm_win[b]    = v_spm_has && !w_cache_win[b];
         w_spm_sel[b]    = r_rr[b];
         v_found         = 1'b0;
         for (int k = 0; k < NumSpmPorts; k++) begin
            v_idx = (32'(r_rr[b]) + 32'(k)) % NumSpmPorts;
            if (!v_found && w_spm_hit[b][v_idx]) begin
               v_found      = 1'b1;
               w_spm_sel[b] = SpmIdxW'(v_idx);
            end
         end
      end
   end

   // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
   always_comb begin
      cache_gnt_o = '0;
      spm_gnt_o   = '0;
      for (int b = 0; b < NumBanks; b++) begin
         w_bank_go[b]   = w_accept && (w_cache_win[b] || w_spm_win[b]);
         w_bank_src[b]  = w_spm_win[b];
         w_bank_port[b] = w_spm_sel[b];
         cache_gnt_o[b] = w_accept && w_cache_win[b];
         if (w_spm_win[b]) begin
            w_bank_we[b]    = spm_we_i[w_spm_sel[b]];
            w_bank_addr[b]  = spm_addr_i[32'(w_spm_sel[b])*MemAddrWidth + BankSelWidth +: BankAddrWidth];
            w_bank_wdata[b] = spm_wdata_i[32'(w_spm_sel[b])*DataWidth +: DataWidth];
            w_bank_be[b]    = spm_be_i[32'(w_spm_sel[b])*BeWidth +: BeWidth];
            if (w_accept) spm_gnt_o[w_spm_sel[b]] = 1'b1;
         end else begin
            w_bank_we[b]    = cache_we_i[b];
            w_bank_addr[b]  = cache_addr_i[b*BankAddrWidth +: BankAddrWidth];
            w_bank_wdata[b] = cache_wdata_i[b*DataWidth +: DataWidth];
            w_bank_be[b]    = cache_be_i[b*BeWidth +: BeWidth];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) begin
            r_starve[b] <= '0;
            r_rr[b]     <= '0;
         end
      end else if (w_accept) begin
         for (int b = 0; b < NumBanks; b++) begin
            if (!w_nondef_req[b] || (w_owned[b] ? w_cache_win[b] : w_spm_win[b]))
               r_starve[b] <= '0;
            else
               r_starve[b] <= r_starve[b] + StarveW'(1);
            if (w_spm_win[b])
               r_rr[b] <= SpmIdxW'((32'(w_spm_sel[b]) + 32'd1) % NumSpmPorts);
         end
      end
   end

   // Response routing tags are flushed by reset so pre-reset reads never return.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) begin
            r_pv[b] <= '0;
            r_ps[b] <= '0;
            for (int s = 0; s < Lat; s++) r_pp[b][s] <= '0;
         end
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            r_pv[b][0] <= w_bank_go[b] && !w_bank_we[b];
            r_ps[b][0] <= w_bank_src[b];
            r_pp[b][0] <= w_bank_port[b];
            for (int s = 1; s < Lat; s++) begin
               r_pv[b][s] <= r_pv[b][s-1];
               r_ps[b][s] <= r_ps[b][s-1];
               r_pp[b][s] <= r_pp[b][s-1];
            end
         end
      end
   end

   // NOTE: the SRAM array and its read-data stages carry no reset; only the valid tags above do.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NumBanks; b++) begin
         if (w_bank_go[b]) begin
            if (w_bank_we[b]) begin
               for (int i = 0; i < BeWidth; i++)
                  if (w_bank_be[b][i])
                     r_mem[b][w_bank_addr[b]][i*ByteWidth +: ByteWidth] <= w_bank_wdata[b][i*ByteWidth +: ByteWidth];
            end else begin
               r_pd[b][0] <= r_mem[b][w_bank_addr[b]];
            end
         end
         for (int s = 1; s < Lat; s++) r_pd[b][s] <= r_pd[b][s-1];
      end
   end

   always_comb begin
      cache_rvalid_o = '0;
      cache_rdata_o  = '0;
      spm_rvalid_o   = '0;
      spm_rdata_o    = '0;
      w_pipe_busy    = 1'b0;
      for (int b = 0; b < NumBanks; b++) begin
         w_pipe_busy = w_pipe_busy || (|r_pv[b]);
         if (r_pv[b][Lat-1]) begin
            if (r_ps[b][Lat-1]) begin
               spm_rvalid_o[r_pp[b][Lat-1]] = 1'b1;
               spm_rdata_o[32'(r_pp[b][Lat-1])*DataWidth +: DataWidth] = r_pd[b][Lat-1];
            end else begin
               cache_rvalid_o[b] = 1'b1;
               cache_rdata_o[b*DataWidth +: DataWidth] = r_pd[b][Lat-1];
            end
         end
      end
   end

   // Reconfiguration FSM: block grants, wait for outstanding reads, then switch the partition.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (cfg_valid_i) w_state_nxt = DRAIN;
         DRAIN:   if (!w_pipe_busy) w_state_nxt = APPLY;
         APPLY:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_accept    = (r_state == IDLE) && !cfg_valid_i;
      cfg_ready_o = (r_state == APPLY);
   end

   assign w_cfg_clamped  = (cfg_spm_ways_i > CfgWidth'(NumWay)) ? CfgWidth'(NumWay) : cfg_spm_ways_i;
   assign cfg_spm_ways_o = r_spm_ways;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cfg_pend <= '0;
         r_spm_ways <= '0;
      end else begin
         if (r_state == IDLE && cfg_valid_i)   r_cfg_pend <= w_cfg_clamped;
         if (r_state == DRAIN && !w_pipe_busy) r_spm_ways <= r_cfg_pend;
      end
   end

`ifdef SPATZ_SRAM_PERF_EN
   logic [31:0]                   r_perf_conflict, r_perf_starve;
   logic                          w_any_denied;
   logic [$clog2(NumBanks+1)-1:0] w_forced_cnt;
   logic [32:0]                   w_starve_sum;

   always_comb begin
      w_any_denied = (|(cache_req_i & ~cache_gnt_o)) || (|(spm_req_i & ~spm_gnt_o));
      w_forced_cnt = '0;
      for (int b = 0; b < NumBanks; b++)
         if (w_accept && w_force[b]) w_forced_cnt = w_forced_cnt + 1'b1;
      w_starve_sum = {1'b0, r_perf_starve} + 33'(w_forced_cnt);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_perf_conflict <= '0;
         r_perf_starve   <= '0;
      end else begin
         if (w_any_denied && (r_perf_conflict != '1)) r_perf_conflict <= r_perf_conflict + 32'd1;
         r_perf_starve <= w_starve_sum[32] ? '1 : w_starve_sum[31:0];
      end
   end

   assign perf_conflict_o = r_perf_conflict;
   assign perf_starve_o   = r_perf_starve;
`endif

endmodule

// File: tb/tb_spatz_hybrid_sram_ctrl.sv
// Directed bench for spatz_hybrid_sram_ctrl: driver checks grants/config, a monitor scoreboards read responses.
module tb_spatz_hybrid_sram_ctrl;

   localparam int NB  = 8;
   localparam int DW  = 64;
   localparam int BW  = 8;
   localparam int NS  = 2;
   localparam int BAW = 8;
   localparam int MAW = 11;
   localparam int CW  = 3;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [NB-1:0]     cache_req_i, cache_we_i;
   logic [NB*BAW-1:0] cache_addr_i;
   logic [NB*DW-1:0]  cache_wdata_i;
   logic [NB*BW-1:0]  cache_be_i;
   logic [NB-1:0]     cache_gnt_o, cache_rvalid_o;
   logic [NB*DW-1:0]  cache_rdata_o;
   logic [NS-1:0]     spm_req_i, spm_we_i;
   logic [NS*MAW-1:0] spm_addr_i;
   logic [NS*DW-1:0]  spm_wdata_i;
   logic [NS*BW-1:0]  spm_be_i;
   logic [NS-1:0]     spm_gnt_o, spm_rvalid_o;
   logic [NS*DW-1:0]  spm_rdata_o;
   logic [CW-1:0]     cfg_spm_ways_i, cfg_spm_ways_o;
   logic              cfg_valid_i, cfg_ready_o;

   spatz_hybrid_sram_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cache_req_i    (cache_req_i),
      .cache_we_i     (cache_we_i),
      .cache_addr_i   (cache_addr_i),
      .cache_wdata_i  (cache_wdata_i),
      .cache_be_i     (cache_be_i),
      .cache_gnt_o    (cache_gnt_o),
      .cache_rvalid_o (cache_rvalid_o),
      .cache_rdata_o  (cache_rdata_o),
      .spm_req_i      (spm_req_i),
      .spm_we_i       (spm_we_i),
      .spm_addr_i     (spm_addr_i),
      .spm_wdata_i    (spm_wdata_i),
      .spm_be_i       (spm_be_i),
      .spm_gnt_o      (spm_gnt_o),
      .spm_rvalid_o   (spm_rvalid_o),
      .spm_rdata_o    (spm_rdata_o),
      .cfg_spm_ways_i (cfg_spm_ways_i),
      .cfg_valid_i    (cfg_valid_i),
      .cfg_ready_o    (cfg_ready_o),
      .cfg_spm_ways_o (cfg_spm_ways_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit          src;   // 1 = SPM port, 0 = cache bank
      int          idx;
      logic [63:0] data;
      int          due;
   } rsp_t;
   rsp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_cmp(input bit src, input int idx, input logic [63:0] data);
      rsp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_rvalid: src=%0d idx=%0d data=0x%0h, none expected (cycle %0d)", src, idx, data, cyc);
      end else begin
         e = sb.pop_front();
         check("rsp_route", {31'd0, src, idx}, {31'd0, e.src, e.idx});
         check("rsp_data", data, e.data);
         check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
   endtask

   // Monitor: every presented response is matched against the scoreboard.
   always @(negedge clk_i) begin
      logic [63:0] idle_or;
      if (rst_ni) begin
         idle_or = '0;
         for (int b = 0; b < NB; b++) begin
            if (cache_rvalid_o[b]) pop_cmp(1'b0, b, cache_rdata_o[b*DW +: DW]);
            else idle_or = idle_or | cache_rdata_o[b*DW +: DW];
         end
         for (int p = 0; p < NS; p++) begin
            if (spm_rvalid_o[p]) pop_cmp(1'b1, p, spm_rdata_o[p*DW +: DW]);
            else idle_or = idle_or | spm_rdata_o[p*DW +: DW];
         end
         check("rdata_zero_when_idle", idle_or, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic clear_all();
      cache_req_i    = '0; cache_we_i  = '0; cache_addr_i = '0; cache_wdata_i = '0; cache_be_i = '0;
      spm_req_i      = '0; spm_we_i    = '0; spm_addr_i   = '0; spm_wdata_i   = '0; spm_be_i   = '0;
      cfg_spm_ways_i = '0; cfg_valid_i = 1'b0;
   endtask

   task automatic cache_op(input int b, input bit we, input logic [7:0] addr,
                           input logic [63:0] data, input logic [7:0] be);
      cache_req_i[b]              = 1'b1;
      cache_we_i[b]               = we;
      cache_addr_i[b*BAW +: BAW]  = addr;
      cache_wdata_i[b*DW +: DW]   = data;
      cache_be_i[b*BW +: BW]      = be;
   endtask

   task automatic spm_op(input int p, input bit we, input logic [7:0] word, input logic [2:0] bank,
                         input logic [63:0] data, input logic [7:0] be);
      spm_req_i[p]              = 1'b1;
      spm_we_i[p]               = we;
      spm_addr_i[p*MAW +: MAW]  = {word, bank};
      spm_wdata_i[p*DW +: DW]   = data;
      spm_be_i[p*BW +: BW]      = be;
   endtask

   task automatic push_rsp(input bit src, input int idx, input logic [63:0] data);
      rsp_t e;
      e.src = src; e.idx = idx; e.data = data; e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic do_cfg(input logic [CW-1:0] val, input logic [CW-1:0] exp_ways);
      bit seen = 1'b0;
      cfg_valid_i = 1'b1;
      cfg_spm_ways_i = val;
      sample();
      check("cfg_ready_idle", cfg_ready_o, 1'b0);
      step();
      cfg_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sample();
         if (cfg_ready_o) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check("cfg_ready_seen", seen, 1'b1);
      check("cfg_ways_applied", cfg_spm_ways_o, exp_ways);
      step();
   endtask

   localparam logic [63:0] DATA_A = 64'hA5A5_0000_1111_2222;
   localparam logic [63:0] DATA_B = 64'h5A5A_3333_4444_5555;

   initial begin
      clear_all();
      #1;
      sample();
      check("rst_cache_rvalid", cache_rvalid_o, '0);
      check("rst_spm_rvalid", spm_rvalid_o, '0);
      check("rst_cache_rdata", cache_rdata_o[3*DW +: DW], '0);
      check("rst_cfg_ready", cfg_ready_o, 1'b0);
      check("rst_cfg_ways", cfg_spm_ways_o, '0);
      step();
      rst_ni = 1'b1;
      step();

      // Cache write then read of bank 3 word 5
      cache_op(3, 1'b1, 8'd5, 64'hDEAD_BEEF, 8'hFF);
      sample();
      check("cache_wr_gnt", cache_gnt_o, 8'h08);
      step();
      cache_op(3, 1'b0, 8'd5, 64'd0, 8'h00);
      sample();
      check("cache_rd_gnt", cache_gnt_o, 8'h08);
      push_rsp(1'b0, 3, 64'hDEAD_BEEF);
      step();
      clear_all();
      step();

      // Starvation: bank 0 SPM-owned, cache wins every fifth cycle
      do_cfg(3'd1, 3'd1);
      cache_op(0, 1'b1, 8'd0, 64'h1, 8'hFF);
      spm_op(0, 1'b1, 8'd0, 3'd0, 64'h2, 8'hFF);
      for (int i = 0; i < 10; i++) begin
         sample();
         check("starve_cache_gnt", cache_gnt_o[0], (i % 5) == 4);
         check("starve_spm_gnt", spm_gnt_o[0], (i % 5) != 4);
         step();
      end
      clear_all();

      // Round-robin between SPM ports on cache-owned bank 6
      spm_op(0, 1'b1, 8'd10, 3'd6, DATA_A, 8'hFF);
      spm_op(1, 1'b1, 8'd11, 3'd6, DATA_B, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         sample();
         check("rr_spm_gnt", spm_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end
      clear_all();
      spm_op(1, 1'b0, 8'd10, 3'd6, 64'd0, 8'h00);
      sample();
      check("rr_rd1_gnt", spm_gnt_o, 2'b10);
      push_rsp(1'b1, 1, DATA_A);
      step();
      clear_all();
      spm_op(0, 1'b0, 8'd11, 3'd6, 64'd0, 8'h00);
      sample();
      check("rr_rd0_gnt", spm_gnt_o, 2'b01);
      push_rsp(1'b1, 0, DATA_B);
      step();
      clear_all();
      step();

      // Reconfiguration with a read in flight
      cache_op(3, 1'b0, 8'd5, 64'd0, 8'h00);
      sample();
      check("drain_rd_gnt", cache_gnt_o, 8'h08);
      push_rsp(1'b0, 3, 64'hDEAD_BEEF);
      step();
      clear_all();
      cache_op(2, 1'b1, 8'd0, 64'h77, 8'hFF);
      cfg_valid_i = 1'b1;
      cfg_spm_ways_i = 3'd2;
      sample();
      check("cfg_same_cycle_gnt", cache_gnt_o, '0);
      step();
      cfg_valid_i = 1'b0;
      sample();
      check("drain_gnt", cache_gnt_o, '0);
      check("drain_ready", cfg_ready_o, 1'b0);
      step();
      sample();
      check("apply_gnt", cache_gnt_o, '0);
      check("apply_ready", cfg_ready_o, 1'b1);
      check("apply_ways", cfg_spm_ways_o, 3'd2);
      step();
      sample();
      check("post_cfg_gnt", cache_gnt_o, 8'h04);
      check("post_cfg_ready", cfg_ready_o, 1'b0);
      step();
      clear_all();

      // Out-of-range partition clamps; bank 7 becomes SPM-default
      do_cfg(3'd7, 3'd4);
      cache_op(7, 1'b1, 8'd1, 64'h3, 8'hFF);
      spm_op(1, 1'b1, 8'd1, 3'd7, 64'h4, 8'hFF);
      sample();
      check("clamp_spm_gnt", spm_gnt_o, 2'b10);
      check("clamp_cache_gnt", cache_gnt_o, '0);
      step();
      clear_all();

      // Byte-enable write then read-back on SPM port 0
      spm_op(0, 1'b1, 8'd20, 3'd1, 64'd0, 8'hFF);
      sample();
      check("be_clr_gnt", spm_gnt_o, 2'b01);
      step();
      spm_op(0, 1'b1, 8'd20, 3'd1, 64'h1122_3344_5566_7788, 8'h0F);
      sample();
      check("be_wr_gnt", spm_gnt_o, 2'b01);
      step();
      spm_op(0, 1'b0, 8'd20, 3'd1, 64'd0, 8'h00);
      sample();
      check("be_rd_gnt", spm_gnt_o, 2'b01);
      push_rsp(1'b1, 0, 64'h0000_0000_5566_7788);
      step();
      clear_all();
      step();

      // Reset while a read is in flight: the response must never appear
      spm_op(0, 1'b0, 8'd20, 3'd1, 64'd0, 8'h00);
      sample();
      check("rst_rd_gnt", spm_gnt_o, 2'b01);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      clear_all();
      sample();
      check("midrst_spm_rvalid", spm_rvalid_o, '0);
      check("midrst_cfg_ways", cfg_spm_ways_o, '0);
      step();
      step();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("postrst_spm_rvalid", spm_rvalid_o, '0);
         check("postrst_cache_rvalid", cache_rvalid_o, '0);
         step();
      end

      check("sb_left", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
